mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares one single-ported, synchronous-read RAM between the RI5CY instruction-fetch and data (load/store) interfaces. It sits between `riscv_core` and a single-port memory in the Verilator model. It grants at most one request per cycle using round-robin priority, and routes the response back to the owning requester one cycle later. It also keeps per-port contention-stall counters for the simulation harness.

## Interface
- `ADDR_WIDTH`, default 22: byte-address width of both requester ports.
- `DATA_WIDTH`, default 32: data width; must be 32 (4 byte enables).
- `CNT_WIDTH`, default 16: width of each stall counter.

Ports:
- `clk_i` input 1: clock; all state changes on the rising edge.
- `rstn_i` input 1: reset, asynchronous, active-low.
- `instr_req_i` input 1: instruction fetch request.
- `instr_addr_i` input ADDR_WIDTH: fetch byte address.
- `instr_gnt_o` output 1: fetch request accepted this cycle.
- `instr_rvalid_o` output 1: fetch data valid.
- `instr_rdata_o` output 32: fetch data.
- `data_req_i` input 1: load/store request.
- `data_addr_i` input ADDR_WIDTH: load/store byte address.
- `data_we_i` input 1: 1 = store.
- `data_be_i` input 4: byte enables.
- `data_wdata_i` input 32: store data.
- `data_gnt_o` output 1: load/store accepted this cycle.
- `data_rvalid_o` output 1: load data valid, or store completion.
- `data_rdata_o` output 32: load data.
- `mem_req_o` output 1: memory access this cycle.
- `mem_addr_o` output ADDR_WIDTH-2: word address.
- `mem_we_o` output 1: memory write.
- `mem_be_o` output 4: memory byte enables.
- `mem_wdata_o` output 32: memory write data.
- `mem_rdata_i` input 32: read data, valid the cycle after `mem_req_o`.
- `cnt_clr_i` input 1: synchronous clear of both stall counters.
- `instr_stall_cnt_o` output CNT_WIDTH: cycles where `instr_req_i` was high and `instr_gnt_o` low.
- `data_stall_cnt_o` output CNT_WIDTH: cycles where `data_req_i` was high and `data_gnt_o` low.

## Operation
**Grant logic** (combinational from requests and the `prio` register):
- If only one port requests, that port is granted.
- If both ports request, the port named by `prio` is granted.
- At most one grant is asserted per cycle.

**`prio` register** (1 bit; 0 = data favoured, 1 = instr favoured):
- Resets to 0.
- After any grant, `prio` points at the other port.
- Unchanged when there is no grant.

**Memory port muxing:**
- `mem_req_o` = `instr_gnt_o` | `data_gnt_o`.
- Address, we, be and wdata come from the granted port.
- An instruction access drives `mem_we_o`=0, `mem_be_o`=4'hF and `mem_wdata_o`=0.
- `mem_addr_o` = granted `addr[ADDR_WIDTH-1:2]`; address bits [1:0] are ignored.
- When idle, all `mem_*` outputs are driven to 0.

**Response tracking:** register `rsp_valid`/`rsp_owner` captures the grant on each edge.
- `instr_rvalid_o` = `rsp_valid` & (`rsp_owner` == instr).
- `data_rvalid_o` = `rsp_valid` & (`rsp_owner` == data).
- Stores also produce `data_rvalid_o`, with `data_rdata_o` don't-care.
- `instr_rdata_o` and `data_rdata_o` are both `mem_rdata_i` (unqualified); requesters sample them only when their rvalid is high.

**Stall counters:**
- Increment when request is high and grant is low.
- Saturate at all-ones; no wrap.
- `cnt_clr_i` takes precedence over increment; the counter reads 0 the next cycle.

## Timing
- Grant is zero-latency, in the same cycle as the request.
- Response latency is exactly 1 cycle after grant. Back-to-back grants are allowed every cycle, for full throughput.
- A requester holds req/addr/we/be/wdata stable until it sees gnt. The arbiter does not require this, but a dropped un-granted request is simply not served.
- Grant is never withdrawn within a cycle once the inputs are stable; there is no combinational path from `mem_rdata_i` to any grant.
- Under sustained contention the grants alternate strictly: D, I, D, I…
- Each port waits at most 1 cycle under contention.

**Reset (asynchronous, `rstn_i` low):**
- `prio`, `rsp_valid`, `rsp_owner` and both counters clear to 0.
- All rvalid outputs go to 0 immediately.
- While reset is asserted, gnt outputs and `mem_req_o` are forced to 0.
- A response in flight at reset is dropped and never delivered.

**Simultaneous events:** in the same cycle as an outstanding rvalid, a new grant is accepted; the response and the new access overlap.

## Test plan
- **Reset state:** assert `rstn_i`=0 mid-transfer → all gnt, rvalid and `mem_req_o` outputs read 0 at once. After release, both counters read 0 and `prio`=data.
- **Instruction-only fetch:** memory preloaded with word 0x00000013 at word 0x20; `instr_req_i`=1, `instr_addr_i`=0x80 → same cycle: `instr_gnt_o`=1 and `mem_addr_o`=0x20. Next cycle: `instr_rvalid_o`=1 and `instr_rdata_o`=0x00000013; `data_rvalid_o`=0.
- **Store then load:** `data_we_i`=1, `data_be_i`=4'b0011, addr 0x100, wdata 0xAABBCCDD over old word 0x11223344 → `data_rvalid_o` 1 cycle after gnt. A following load of 0x100 returns 0x1122CCDD.
- **Sustained contention:** both requests held high for 6 cycles, from reset → grant sequence D, I, D, I, D, I. rvalid routes each response to the correct port one cycle later. Each stall counter reads 3.
- **Counter saturation and clear:** `CNT_WIDTH`=4, instr request held high under contention for 40 cycles → `instr_stall_cnt_o` stops at 0xF. Pulse `cnt_clr_i` concurrently with a stall → counter reads 0 the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read, single-port RAM between the
// RI5CY instruction-fetch and load/store interfaces, with per-port stall counters.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32,  // byte-enable logic assumes exactly 32
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,

  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,

  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,

  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  input  logic                  cnt_clr_i,
  output logic [CNT_WIDTH-1:0]  instr_stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  data_stall_cnt_o
);

  // Handshake: a request is accepted in the cycle where req and gnt are both
  // high; exactly one cycle later rvalid pulses on the owning port (loads carry
  // rdata, stores only signal completion). An un-granted request is not queued.

  localparam logic OWNER_DATA  = 1'b0;
  localparam logic OWNER_INSTR = 1'b1;

  logic prio;       // 0: data favoured, 1: instr favoured
  logic rsp_valid;
  logic rsp_owner;
  logic instr_gnt;
  logic data_gnt;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  // Grants depend only on requests, prio and reset -- never on mem_rdata_i.
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (rstn_i) begin
      if (instr_req_i && data_req_i) begin
        if (prio == OWNER_INSTR) instr_gnt = 1'b1;
        else                     data_gnt  = 1'b1;
      end else if (instr_req_i) begin
        instr_gnt = 1'b1;
      end else if (data_req_i) begin
        data_gnt = 1'b1;
      end
    end
  end

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = '0;
    if (data_gnt) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = data_addr_i[ADDR_WIDTH-1:2];
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else if (instr_gnt) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = instr_addr_i[ADDR_WIDTH-1:2];
      mem_be_o    = 4'hF;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prio      <= OWNER_DATA;
      rsp_valid <= 1'b0;
      rsp_owner <= OWNER_DATA;
    end else begin
      if (instr_gnt)     prio <= OWNER_DATA;
      else if (data_gnt) prio <= OWNER_INSTR;
      rsp_valid <= instr_gnt | data_gnt;
      rsp_owner <= instr_gnt ? OWNER_INSTR : OWNER_DATA;
    end
  end

  assign instr_rvalid_o = rsp_valid && (rsp_owner == OWNER_INSTR);
  assign data_rvalid_o  = rsp_valid && (rsp_owner == OWNER_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  // Stall counters saturate so long contention runs never read as small values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      instr_stall_cnt_o <= '0;
      data_stall_cnt_o  <= '0;
    end else if (cnt_clr_i) begin
      instr_stall_cnt_o <= '0;
      data_stall_cnt_o  <= '0;
    end else begin
      if (instr_req_i && !instr_gnt && !(&instr_stall_cnt_o))
        instr_stall_cnt_o <= instr_stall_cnt_o + 1'b1;
      if (data_req_i && !data_gnt && !(&data_stall_cnt_o))
        data_stall_cnt_o <= data_stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store/load, contention,
// counter saturation and clear, against a small behavioural RAM.
module tb_mem_port_arbiter;

  localparam int AW = 22;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          instr_req, data_req, data_we, cnt_clr;
  logic [AW-1:0] instr_addr, data_addr;
  logic [3:0]    data_be;
  logic [31:0]   data_wdata, mem_rdata;

  logic          instr_gnt, instr_rvalid, data_gnt, data_rvalid, mem_req, mem_we;
  logic [31:0]   instr_rdata, data_rdata, mem_wdata;
  logic [AW-3:0] mem_addr;
  logic [3:0]    mem_be;
  logic [15:0]   instr_cnt, data_cnt;

  logic          d4_instr_gnt, d4_instr_rvalid, d4_data_gnt, d4_data_rvalid, d4_mem_req, d4_mem_we;
  logic [31:0]   d4_instr_rdata, d4_data_rdata, d4_mem_wdata;
  logic [AW-3:0] d4_mem_addr;
  logic [3:0]    d4_mem_be;
  logic [3:0]    d4_instr_cnt, d4_data_cnt;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .cnt_clr_i(cnt_clr), .instr_stall_cnt_o(instr_cnt), .data_stall_cnt_o(data_cnt)
  );

  // Narrow-counter instance, same stimulus, used for saturation checks.
  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rstn_i(rstn),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(d4_instr_gnt),
    .instr_rvalid_o(d4_instr_rvalid), .instr_rdata_o(d4_instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(d4_data_gnt),
    .data_rvalid_o(d4_data_rvalid), .data_rdata_o(d4_data_rdata),
    .mem_req_o(d4_mem_req), .mem_addr_o(d4_mem_addr), .mem_we_o(d4_mem_we),
    .mem_be_o(d4_mem_be), .mem_wdata_o(d4_mem_wdata), .mem_rdata_i(mem_rdata),
    .cnt_clr_i(cnt_clr), .instr_stall_cnt_o(d4_instr_cnt), .data_stall_cnt_o(d4_data_cnt)
  );

  // Behavioural single-port RAM, preloaded while reset is low.
  logic [31:0] ram [256];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram[8'h20] <= 32'h0000_0013;
      ram[8'h40] <= 32'h1122_3344;
      mem_rdata  <= '0;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[7:0]];
      end
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    instr_req  = 1'b0;
    instr_addr = '0;
    data_req   = 1'b0;
    data_addr  = '0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_wdata = '0;
  endtask

  initial begin
    drive_idle();
    cnt_clr = 1'b0;
    rstn    = 1'b0;

    // Requests during reset must not be granted.
    instr_req  = 1'b1;
    instr_addr = 22'h80;
    #2;
    check("rst_instr_gnt", {31'd0, instr_gnt}, 32'd0);
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    tick();
    tick();
    drive_idle();
    rstn = 1'b1;
    #1;
    check("rst_instr_cnt", {16'd0, instr_cnt}, 32'd0);
    check("rst_data_cnt",  {16'd0, data_cnt},  32'd0);
    check("rst_rvalid",    {30'd0, instr_rvalid, data_rvalid}, 32'd0);
    tick();

    // Instruction-only fetch.
    instr_req  = 1'b1;
    instr_addr = 22'h80;
    #1;
    check("if_gnt",      {30'd0, instr_gnt, data_gnt}, 32'h2);
    check("if_mem_addr", {12'd0, mem_addr}, 32'h20);
    check("if_mem_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
    tick();
    drive_idle();
    check("if_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h2);
    check("if_rdata",  instr_rdata, 32'h0000_0013);

    // Partial store over 0x11223344.
    data_req   = 1'b1;
    data_addr  = 22'h100;
    data_we    = 1'b1;
    data_be    = 4'b0011;
    data_wdata = 32'hAABB_CCDD;
    #1;
    check("st_gnt",       {30'd0, instr_gnt, data_gnt}, 32'h1);
    check("st_mem_addr",  {12'd0, mem_addr}, 32'h40);
    check("st_mem_we_be", {27'd0, mem_we, mem_be}, 32'h13);
    check("st_mem_wdata", mem_wdata, 32'hAABB_CCDD);
    tick();
    drive_idle();
    check("st_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h1);

    // Load back the merged word.
    data_req  = 1'b1;
    data_addr = 22'h100;
    #1;
    check("ld_gnt", {30'd0, instr_gnt, data_gnt}, 32'h1);
    tick();
    drive_idle();
    check("ld_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h1);
    check("ld_rdata",  data_rdata, 32'h1122_CCDD);

    // Reset with a fetch response outstanding and the request still high.
    instr_req  = 1'b1;
    instr_addr = 22'h80;
    tick();
    check("mid_rvalid_pre", {31'd0, instr_rvalid}, 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
    check("mid_gnt",    {30'd0, instr_gnt, data_gnt}, 32'd0);
    check("mid_mem_req", {31'd0, mem_req}, 32'd0);
    drive_idle();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("mid_dropped", {30'd0, instr_rvalid, data_rvalid}, 32'd0);

    // Sustained contention from reset: D, I, D, I, D, I.
    instr_req  = 1'b1;
    instr_addr = 22'h80;
    data_req   = 1'b1;
    data_addr  = 22'h100;
    data_wdata = 32'h5555_AAAA;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k % 2 == 0) begin
        check($sformatf("ct_gnt%0d", k), {30'd0, instr_gnt, data_gnt}, 32'h1);
        check($sformatf("ct_addr%0d", k), {12'd0, mem_addr}, 32'h40);
      end else begin
        check($sformatf("ct_gnt%0d", k), {30'd0, instr_gnt, data_gnt}, 32'h2);
        check($sformatf("ct_ibus%0d", k), {27'd0, mem_we, mem_be}, 32'h0F);
        check($sformatf("ct_iwd%0d", k), mem_wdata, 32'h0);
      end
      if (k > 0) begin
        if (k % 2 == 1) begin
          check($sformatf("ct_rv%0d", k), {30'd0, instr_rvalid, data_rvalid}, 32'h1);
          check($sformatf("ct_rd%0d", k), data_rdata, 32'h1122_3344);
        end else begin
          check($sformatf("ct_rv%0d", k), {30'd0, instr_rvalid, data_rvalid}, 32'h2);
          check($sformatf("ct_rd%0d", k), instr_rdata, 32'h0000_0013);
        end
      end
      tick();
    end
    drive_idle();
    #1;
    check("ct_rv_last", {30'd0, instr_rvalid, data_rvalid}, 32'h2);
    check("ct_rd_last", instr_rdata, 32'h0000_0013);
    check("ct_instr_cnt", {16'd0, instr_cnt}, 32'd3);
    check("ct_data_cnt",  {16'd0, data_cnt},  32'd3);
    check("ct_d4_cnts",   {24'd0, d4_instr_cnt, d4_data_cnt}, 32'h33);

    // Clear, then 40 cycles of contention: 20 stalls per port.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_idle", {instr_cnt, data_cnt}, 32'd0);
    instr_req  = 1'b1;
    instr_addr = 22'h80;
    data_req   = 1'b1;
    data_addr  = 22'h100;
    repeat (40) tick();
    check("sat_instr_cnt16", {16'd0, instr_cnt}, 32'd20);
    check("sat_data_cnt16",  {16'd0, data_cnt},  32'd20);
    check("sat_instr_cnt4",  {28'd0, d4_instr_cnt}, 32'hF);
    check("sat_data_cnt4",   {28'd0, d4_data_cnt},  32'hF);

    // Clear wins over a concurrent stall; next cycle data stalls (instr granted).
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_stall_cnt16", {instr_cnt, data_cnt}, 32'd0);
    check("clr_stall_cnt4",  {24'd0, d4_instr_cnt, d4_data_cnt}, 32'd0);
    tick();
    check("post_clr_cnt16", {instr_cnt, data_cnt}, 32'h0000_0001);
    check("post_clr_cnt4",  {24'd0, d4_instr_cnt, d4_data_cnt}, 32'h01);

    // Idle memory bus drives zeros.
    drive_idle();
    #1;
    check("idle_mem_ctl",   {12'd0, mem_addr}, 32'd0);
    check("idle_mem_req",   {27'd0, mem_req, mem_be}, 32'd0);
    check("idle_mem_wdata", {31'd0, mem_we} | mem_wdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
